// File: rtl/audio_mix_vol.sv
// audio_mix_vol: per-source and master volume mixer for the OPM and VERA stereo streams.
// A single shared multiplier is stepped through the mix by an FSM. Volume and status registers sit on the I/O bus.
module audio_mix_vol #(
    parameter int VOL_W = 8,
    parameter int SHIFT = 7
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cs_n,
    input  logic               rd_n,
    input  logic               wr_n,
    input  logic [1:0]         addr,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               dout_en,
    input  logic signed [15:0] opm_l,
    input  logic signed [15:0] opm_r,
    input  logic signed [15:0] va_l,
    input  logic signed [15:0] va_r,
    input  logic               sample_req,
    output logic signed [15:0] l_out,
    output logic signed [15:0] r_out,
    output logic               out_valid
);
    localparam int SAMP_W = 16;
    localparam int ACC_W  = SAMP_W + VOL_W + 2;
    localparam int MA_W   = ACC_W - SHIFT;
    localparam int MIX_W  = MA_W + VOL_W + 1;
    localparam logic [VOL_W-1:0] VOL_UNITY = VOL_W'(1) << (VOL_W - 1);
    localparam logic [VOL_W-1:0] VOL_HALF  = VOL_W'(1) << (VOL_W - 2);
    localparam logic signed [MIX_W-1:0] SAT_HI = MIX_W'((2 ** (SAMP_W - 1)) - 1);
    localparam logic signed [MIX_W-1:0] SAT_LO = -SAT_HI - MIX_W'(1);

    // Volumes are unsigned: zero-extend so the signed multiply treats them as positive.
    function automatic logic signed [MIX_W-1:0] vol_ext(input logic [VOL_W-1:0] v);
        return $signed(MIX_W'(v));
    endfunction

    // Returns {clipped, saturated sample}.
    function automatic logic [SAMP_W:0] sat16(input logic signed [MIX_W-1:0] v);
        if (v > SAT_HI) return {1'b1, SAT_HI[SAMP_W-1:0]};
        if (v < SAT_LO) return {1'b1, SAT_LO[SAMP_W-1:0]};
        return {1'b0, v[SAMP_W-1:0]};
    endfunction

    typedef enum logic [3:0] {
        S_IDLE, S_CAP, S_ML1, S_ML2, S_MR1, S_MR2, S_GL, S_GR, S_SAT
    } state_t;

    state_t                    state_q, state_d;
    logic                      cs_s1_q, cs_s2_q, wr_s1_q, wr_s2_q, strb_q;
    logic                      wr_strb, wr_commit, busy, ovr_set;
    logic [1:0]                waddr_q, waddr_d;
    logic [7:0]                wdata_q, wdata_d;
    logic [VOL_W-1:0]          vol_opm_q, vol_opm_d, vol_vera_q, vol_vera_d, vol_mst_q, vol_mst_d;
    logic [VOL_W-1:0]          sh_vo_q, sh_vo_d, sh_vv_q, sh_vv_d, sh_vm_q, sh_vm_d;
    logic                      clip_q, clip_d, ovr_q, ovr_d, out_valid_q, out_valid_d;
    logic signed [SAMP_W-1:0]  smp_ol_q, smp_ol_d, smp_or_q, smp_or_d;
    logic signed [SAMP_W-1:0]  smp_vl_q, smp_vl_d, smp_vr_q, smp_vr_d;
    logic signed [SAMP_W-1:0]  l_out_q, l_out_d, r_out_q, r_out_d;
    logic signed [ACC_W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [MIX_W-1:0]   mix_l_q, mix_l_d, mix_r_q, mix_r_d, mul_a, mul_b, prod;
    logic [SAMP_W:0]           sat_l, sat_r;

    // Write strobe falls 2-3 clocks after the bus releases; commit the captured addr/data then.
    assign wr_strb   = ~cs_s2_q & ~wr_s2_q;
    assign wr_commit = strb_q & ~wr_strb;
    assign busy      = (state_q != S_IDLE);
    assign dout_en   = ~cs_n & ~rd_n;
    assign prod      = mul_a * mul_b;
    assign sat_l     = sat16(mix_l_q >>> SHIFT);
    assign sat_r     = sat16(mix_r_q >>> SHIFT);
    assign l_out     = l_out_q;
    assign r_out     = r_out_q;
    assign out_valid = out_valid_q;

    always_comb begin
        case (addr)
            2'd0:    dout = 8'(vol_opm_q);
            2'd1:    dout = 8'(vol_vera_q);
            2'd2:    dout = 8'(vol_mst_q);
            default: dout = {busy, 5'b0, ovr_q, clip_q};
        endcase
    end

    always_comb begin
        waddr_d    = wr_strb ? addr : waddr_q;
        wdata_d    = wr_strb ? din  : wdata_q;
        vol_opm_d  = vol_opm_q;
        vol_vera_d = vol_vera_q;
        vol_mst_d  = vol_mst_q;
        if (wr_commit) begin
            case (waddr_q)
                2'd0:    vol_opm_d  = VOL_W'(wdata_q);
                2'd1:    vol_vera_d = VOL_W'(wdata_q);
                2'd2:    vol_mst_d  = VOL_W'(wdata_q);
                default: ;
            endcase
        end
    end

    // SAT can accept a new request directly so back-to-back samples need no idle cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sample_req) state_d = S_CAP;
            S_CAP:   state_d = S_ML1;
            S_ML1:   state_d = S_ML2;
            S_ML2:   state_d = S_MR1;
            S_MR1:   state_d = S_MR2;
            S_MR2:   state_d = S_GL;
            S_GL:    state_d = S_GR;
            S_GR:    state_d = S_SAT;
            S_SAT:   state_d = sample_req ? S_CAP : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ovr_set = sample_req && !(state_q inside {S_IDLE, S_SAT});
    end

    always_comb begin
        smp_ol_d = smp_ol_q;
        smp_or_d = smp_or_q;
        smp_vl_d = smp_vl_q;
        smp_vr_d = smp_vr_q;
        sh_vo_d  = sh_vo_q;
        sh_vv_d  = sh_vv_q;
        sh_vm_d  = sh_vm_q;
        acc_l_d  = acc_l_q;
        acc_r_d  = acc_r_q;
        mix_l_d  = mix_l_q;
        mix_r_d  = mix_r_q;
        mul_a    = '0;
        mul_b    = '0;
        l_out_d  = l_out_q;
        r_out_d  = r_out_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_CAP: begin
                smp_ol_d = opm_l;
                smp_or_d = opm_r;
                smp_vl_d = va_l;
                smp_vr_d = va_r;
                sh_vo_d  = vol_opm_q;
                sh_vv_d  = vol_vera_q;
                sh_vm_d  = vol_mst_q;
            end
            S_ML1: begin
                mul_a   = MIX_W'(smp_ol_q);
                mul_b   = vol_ext(sh_vo_q);
                acc_l_d = ACC_W'(prod);
            end
            S_ML2: begin
                mul_a   = MIX_W'(smp_vl_q);
                mul_b   = vol_ext(sh_vv_q);
                acc_l_d = acc_l_q + ACC_W'(prod);
            end
            S_MR1: begin
                mul_a   = MIX_W'(smp_or_q);
                mul_b   = vol_ext(sh_vo_q);
                acc_r_d = ACC_W'(prod);
            end
            S_MR2: begin
                mul_a   = MIX_W'(smp_vr_q);
                mul_b   = vol_ext(sh_vv_q);
                acc_r_d = acc_r_q + ACC_W'(prod);
            end
            S_GL: begin
                mul_a   = MIX_W'(acc_l_q >>> SHIFT);
                mul_b   = vol_ext(sh_vm_q);
                mix_l_d = prod;
            end
            S_GR: begin
                mul_a   = MIX_W'(acc_r_q >>> SHIFT);
                mul_b   = vol_ext(sh_vm_q);
                mix_r_d = prod;
            end
            S_SAT: begin
                l_out_d     = $signed(sat_l[SAMP_W-1:0]);
                r_out_d     = $signed(sat_r[SAMP_W-1:0]);
                out_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Set events take priority over a same-cycle clear.
    always_comb begin
        clip_d = clip_q;
        ovr_d  = ovr_q;
        if (wr_commit && waddr_q == 2'd3) begin
            if (wdata_q[0]) clip_d = 1'b0;
            if (wdata_q[1]) ovr_d  = 1'b0;
        end
        if (state_q == S_SAT && (sat_l[SAMP_W] || sat_r[SAMP_W])) clip_d = 1'b1;
        if (ovr_set) ovr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            {cs_s2_q, cs_s1_q} <= 2'b11;
            {wr_s2_q, wr_s1_q} <= 2'b11;
            strb_q      <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            vol_opm_q   <= VOL_HALF;
            vol_vera_q  <= VOL_HALF;
            vol_mst_q   <= VOL_UNITY;
            clip_q      <= 1'b0;
            ovr_q       <= 1'b0;
            l_out_q     <= '0;
            r_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            {cs_s2_q, cs_s1_q} <= {cs_s1_q, cs_n};
            {wr_s2_q, wr_s1_q} <= {wr_s1_q, wr_n};
            strb_q      <= wr_strb;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            vol_opm_q   <= vol_opm_d;
            vol_vera_q  <= vol_vera_d;
            vol_mst_q   <= vol_mst_d;
            clip_q      <= clip_d;
            ovr_q       <= ovr_d;
            l_out_q     <= l_out_d;
            r_out_q     <= r_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        smp_ol_q <= smp_ol_d;
        smp_or_q <= smp_or_d;
        smp_vl_q <= smp_vl_d;
        smp_vr_q <= smp_vr_d;
        sh_vo_q  <= sh_vo_d;
        sh_vv_q  <= sh_vv_d;
        sh_vm_q  <= sh_vm_d;
        acc_l_q  <= acc_l_d;
        acc_r_q  <= acc_r_d;
        mix_l_q  <= mix_l_d;
        mix_r_q  <= mix_r_d;
    end
endmodule

// File: tb/tb_audio_mix_vol.sv
// Directed and randomized bench for audio_mix_vol against an arithmetic (floor-division) reference model.
module tb_audio_mix_vol;
    logic clk = 1'b0;
    logic resetn, cs_n, rd_n, wr_n, dout_en, sample_req, out_valid;
    logic [1:0] addr;
    logic [7:0] din, dout, rd_d;
    logic rd_en;
    logic signed [15:0] opm_l, opm_r, va_l, va_r, l_out, r_out;
    logic signed [15:0] r0, r1, r2, r3;
    int errors = 0, checks = 0;
    int cur_vo = 64, cur_vv = 64, cur_vm = 128;
    bit exp_clip = 0, exp_ovr = 0;
    int el, er, n;
    bit cl, cr;

    audio_mix_vol dut (
        .clk(clk), .resetn(resetn), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .addr(addr), .din(din), .dout(dout), .dout_en(dout_en),
        .opm_l(opm_l), .opm_r(opm_r), .va_l(va_l), .va_r(va_r),
        .sample_req(sample_req), .l_out(l_out), .r_out(r_out), .out_valid(out_valid)
    );

    always #20 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic longint fdiv(input longint v, input longint d);
        longint q;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    // One channel: (s1*vo + s2*vv)/128 floored, times master, /128 floored, clamped to 16 bits.
    function automatic int model_ch(input int s1, input int s2, input int vo, input int vv,
                                    input int vm, output bit clipped);
        longint acc, m;
        acc = longint'(s1) * vo + longint'(s2) * vv;
        m = fdiv(fdiv(acc, 128) * vm, 128);
        clipped = 0;
        if (m > 32767) begin m = 32767; clipped = 1; end
        else if (m < -32768) begin m = -32768; clipped = 1; end
        return int'(m);
    endfunction

    function automatic int status_exp();
        return (int'(exp_ovr) << 1) | int'(exp_clip);
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] d, output logic en);
        addr = a; cs_n = 0; rd_n = 0;
        #2;
        d = dout; en = dout_en;
        cs_n = 1; rd_n = 1;
        #2;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input int exp);
        logic [7:0] d;
        logic en;
        read_reg(a, d, en);
        check(tag, d, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        addr = a; din = d; cs_n = 0; wr_n = 0;
        repeat (3) tick();
        cs_n = 1; wr_n = 1;
        repeat (4) tick();
        case (a)
            2'd0: cur_vo = d;
            2'd1: cur_vv = d;
            2'd2: cur_vm = d;
            default: begin
                if (d[0]) exp_clip = 0;
                if (d[1]) exp_ovr = 0;
            end
        endcase
    endtask

    task automatic set_inputs(input int ol, input int vl, input int orr, input int vr);
        bit c1, c2;
        opm_l = 16'(ol); va_l = 16'(vl); opm_r = 16'(orr); va_r = 16'(vr);
        el = model_ch(ol, vl, cur_vo, cur_vv, cur_vm, c1);
        er = model_ch(orr, vr, cur_vo, cur_vv, cur_vm, c2);
        cl = c1; cr = c2;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < 20) begin tick(); k++; end
        check({tag, "_lat"}, k, 8);
        check({tag, "_l"}, l_out, el);
        check({tag, "_r"}, r_out, er);
        if (cl || cr) exp_clip = 1;
        tick();
        check({tag, "_vpulse"}, out_valid, 0);
    endtask

    task automatic run_sample(input string tag, input int ol, input int vl, input int orr, input int vr);
        set_inputs(ol, vl, orr, vr);
        sample_req = 1;
        tick();
        sample_req = 0;
        wait_valid(tag);
    endtask

    initial begin
        resetn = 0; cs_n = 1; rd_n = 1; wr_n = 1; addr = 0; din = 0;
        opm_l = 0; opm_r = 0; va_l = 0; va_r = 0; sample_req = 0;
        repeat (3) tick();
        check("rst_l", l_out, 0);
        check("rst_r", r_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_en_idle", dout_en, 0);
        resetn = 1;
        tick();
        check_reg("rst_reg0", 2'd0, 8'h40);
        check_reg("rst_reg1", 2'd1, 8'h40);
        check_reg("rst_reg2", 2'd2, 8'h80);
        check_reg("rst_reg3", 2'd3, 8'h00);

        // Defaults: unity-ish mix with a negative odd result rounding toward -inf.
        run_sample("dflt", 1000, 2000, -3, 0);
        check_reg("dflt_st", 2'd3, status_exp());

        // Master volume write and read-enable behaviour.
        bus_write(2'd2, 8'h40);
        read_reg(2'd2, rd_d, rd_en);
        check("rd_r2", rd_d, 8'h40);
        check("rd_en_on", rd_en, 1);
        check("rd_en_off", dout_en, 0);
        cs_n = 0; #1;
        check("rd_en_cs_only", dout_en, 0);
        cs_n = 1; rd_n = 0; #1;
        check("rd_en_rd_only", dout_en, 0);
        rd_n = 1; #1;
        run_sample("m40", 1000, 2000, 1000, 2000);

        // Full-scale saturation both ways, then clip clear.
        bus_write(2'd0, 8'hFF);
        bus_write(2'd1, 8'hFF);
        run_sample("satp", 32767, 32767, 32767, 32767);
        check_reg("satp_st", 2'd3, status_exp());
        run_sample("satn", -32768, -32768, -32768, -32768);
        bus_write(2'd3, 8'h01);
        check_reg("clip_clr", 2'd3, status_exp());

        // Random volumes and samples.
        for (int i = 0; i < 6; i++) begin
            bus_write(2'd0, 8'($urandom_range(0, 255)));
            bus_write(2'd1, 8'($urandom_range(0, 255)));
            bus_write(2'd2, 8'($urandom_range(0, 255)));
            r0 = 16'($urandom); r1 = 16'($urandom); r2 = 16'($urandom); r3 = 16'($urandom);
            run_sample($sformatf("rnd%0d", i), r0, r1, r2, r3);
            check_reg($sformatf("rnd%0d_st", i), 2'd3, status_exp());
            bus_write(2'd3, 8'h03);
        end

        // Overrun: second request while busy is dropped.
        bus_write(2'd0, 8'h80);
        bus_write(2'd1, 8'h80);
        bus_write(2'd2, 8'h80);
        set_inputs(100, 200, -100, -200);
        sample_req = 1; tick();
        sample_req = 0; tick(); tick();
        sample_req = 1; tick();
        sample_req = 0; exp_ovr = 1;
        tick();
        read_reg(2'd3, rd_d, rd_en);
        check("ovr_busy_bit", rd_d[7], 1);
        check("ovr_bit_early", rd_d[1], 1);
        repeat (3) tick();
        check("ovr_pre_valid", out_valid, 0);
        tick();
        check("ovr_valid", out_valid, 1);
        check("ovr_l", l_out, el);
        check("ovr_r", r_out, er);
        n = 0;
        for (int i = 0; i < 15; i++) begin tick(); if (out_valid === 1'b1) n++; end
        check("ovr_extra_valid", n, 0);
        check_reg("ovr_st", 2'd3, 8'h02);
        bus_write(2'd3, 8'h02);
        check_reg("ovr_clr", 2'd3, status_exp());

        // Volume write landing mid-computation only affects the next sample.
        set_inputs(1000, 2000, -500, 300);
        addr = 2'd0; din = 8'h00; cs_n = 0; wr_n = 0;
        tick();
        sample_req = 1;
        tick();
        sample_req = 0; cs_n = 1; wr_n = 1;
        wait_valid("midw_old");
        cur_vo = 0;
        check_reg("midw_reg0", 2'd0, 8'h00);
        run_sample("midw_new", 1000, 2000, -500, 300);

        // Reset during computation abandons the sample.
        set_inputs(1000, 2000, -500, 300);
        sample_req = 1; tick();
        sample_req = 0;
        repeat (4) tick();
        resetn = 0;
        tick();
        resetn = 1;
        cur_vo = 64; cur_vv = 64; cur_vm = 128; exp_clip = 0; exp_ovr = 0;
        n = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (out_valid === 1'b1) n++; end
        check("arst_no_valid", n, 0);
        check("arst_l", l_out, 0);
        check("arst_r", r_out, 0);
        check_reg("arst_reg0", 2'd0, 8'h40);
        check_reg("arst_reg1", 2'd1, 8'h40);
        check_reg("arst_reg2", 2'd2, 8'h80);
        check_reg("arst_reg3", 2'd3, 8'h00);
        run_sample("post_rst", 1000, 2000, -3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
